sprite_overlay_controller: RTL and testbench
============================================

# sprite_overlay_controller

Parametrised sprite overlay stage for the VGA path. It sits between the VGA timing generator and the pixel output. For each pixel it decides whether a rectangular ROM-backed sprite covers it, reads the sprite colour from an external ROM, applies a colour-key transparency test, and otherwise passes the incoming background colour through. It adds integer scaling, a runtime-movable position with tear-free frame-boundary update, a ROM latency parameter, and three display modes (static, blink, left-to-right reveal).

## Interface
- `SPR_W`, 90: sprite width in ROM pixels.
- `SPR_H`, 11: sprite height in ROM pixels.
- `ROW_W`, 4: ROM row address width; must satisfy 2^ROW_W ≥ SPR_H.
- `COL_W`, 7: ROM column address width; must satisfy 2^COL_W ≥ SPR_W.
- `SCALE_LOG2`, 0: on-screen magnification of 2^SCALE_LOG2 in both axes.
- `X0`, 260: reset horizontal position (left edge, screen pixels).
- `Y0`, 277: reset vertical position (top edge).
- `KEY`, 12'hFFF: transparent colour key.
- `ROM_LAT`, 1: ROM read latency in clk cycles, ≥1.
- `BLINK_FRAMES`, 30: frames per blink half-period, ≥1.
- `REVEAL_STEP`, 2: ROM columns uncovered per frame in reveal mode, ≥1.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: overlay enable.
- `bright` in 1: active-video flag from the timing generator.
- `hCount`, `vCount` in 10 each: current pixel coordinates.
- `background` in 12: colour shown where the sprite is absent or transparent.
- `pos_x`, `pos_y` in 10 each: requested sprite position.
- `pos_load` in 1: one-cycle strobe that captures `pos_x`/`pos_y` into the shadow registers.
- `mode` in 2: 0 static, 1 blink, 2 reveal, 3 treated as static.
- `rom_row` out ROW_W: ROM row address.
- `rom_col` out COL_W: ROM column address.
- `rom_color` in 12: ROM data, valid ROM_LAT cycles after the address.
- `rgb` out 12: registered pixel colour.
- `reveal_done` out 1: level, high when the reveal has completed.

## Operation
- **Frame tick**: asserted on the first cycle where hCount==0 && vCount==0, after a cycle where that condition was false. This is edge-detected, so the block tolerates pixel-rate clock enables.
- **Position**
  - `pos_load` writes the shadow registers and sets `pending`.
  - On a frame tick with `pending` set, the active position takes the shadow value and `pending` clears.
  - If `pos_load` coincides with the tick, the newly presented values are applied at that tick.
  - Reset: active = shadow = (X0, Y0), `pending`=0.
- **Hit test**
  - dx = hCount − ax and dy = vCount − ay, both computed 11 bits wide.
  - hit = en && dx,dy non-negative && dx < SPR_W<<SCALE_LOG2 && dy < SPR_H<<SCALE_LOG2.
  - The window is clipped where it runs past the screen edge; there is no wrap-around.
- **ROM address**: rom_col = dx>>SCALE_LOG2 and rom_row = dy>>SCALE_LOG2, truncated. The addresses are don't-care when hit=0.
- **Mode state**, updated only on a frame tick:
  - `mode_q` latches `mode`. If the value changed, `blink_cnt`=0, `vis`=1 and `reveal_col`=0.
  - Blink: `blink_cnt` counts 0..BLINK_FRAMES−1. At the wrap it returns to 0 and `vis` toggles.
  - Reveal: `reveal_col` increases by REVEAL_STEP and saturates at SPR_W. `reveal_done` = (mode_q==2 && reveal_col==SPR_W).
  - en=0 on any cycle forces `blink_cnt`=0, `vis`=1 and `reveal_col`=0, so the reveal restarts when the block is re-enabled.
- **Show mask**, computed at stage 0:
  - show = hit && (mode_q!=1 || vis) && (mode_q!=2 || rom_col < reveal_col).
  - In reveal mode the first frame shows nothing, because reveal_col starts at 0.
- **Output mux**, registered:
  - if !bright_d: rgb = 0;
  - else if show_d && rom_color != KEY: rgb = rom_color;
  - else: rgb = background_d.

## Timing
- Stage 0 (combinational): hit, show and the ROM address are driven.
- `bright`, `background` and `show` pass through a delay line of ROM_LAT registers, so they are aligned with `rom_color`.
- `rgb` is registered on the next edge.
- End-to-end latency from hCount/vCount/bright/background to rgb is ROM_LAT+1 cycles, fixed in every mode.
- Reset values:
  - `rgb`=0, `reveal_done`=0.
  - Delay lines cleared, which gives black output until they refill.
  - `mode_q`=0, `vis`=1, `blink_cnt`=0, `reveal_col`=0, previous-tick flag=0.
- Reset mid-frame: the position returns to (X0,Y0) immediately, and any pending load is discarded.
- The mode counters change only on the frame tick or on en=0, never mid-frame. The sprite therefore never tears.

## Test plan
- **Static, defaults, ROM model with LAT=1.** Pixel (260,277) with ROM[0][0]=12'h0F0 and bright=1 → rgb=12'h0F0 two cycles later. Pixel (350,277) → background. A ROM word 12'hFFF → background.
- **Scaling, SCALE_LOG2=1.** Pixels (262,279) and (263,280) both → rom_row=1, rom_col=1. Window right edge: hCount 439 is a hit, 440 is not.
- **Move.** pos_load with (100,50) mid-frame → the old position stays in effect until the next frame tick; the sprite appears at (100,50) from that frame on. pos_load in the same cycle as the tick → applied that frame.
- **Blink, BLINK_FRAMES=2.** The sprite is visible in frames 0–1, hidden in frames 2–3 and visible again in frame 4. en=0 for one cycle → visible restarts at frame 0.
- **Reveal, REVEAL_STEP=30.**
  - Frame 0 shows no sprite.
  - Frame 1 shows columns 0–29.
  - Frame 3 shows all 90 columns, and `reveal_done` rises on that tick.
  - Switching to static clears `reveal_done` at the next tick.
- **Blanking and reset.** bright=0 inside the window → rgb=0. rst asserted mid-line → rgb=0 on the following edge, and the position reverts to (260,277).

Source files
------------

// File: rtl/sprite_overlay_controller.sv
// Sprite overlay stage: hit test, ROM addressing, colour-key transparency and
// blink/reveal display modes, with frame-synchronous position and mode updates.
module sprite_overlay_controller #(
    parameter int unsigned SPR_W        = 90,
    parameter int unsigned SPR_H        = 11,
    parameter int unsigned ROW_W        = 4,
    parameter int unsigned COL_W        = 7,
    parameter int unsigned SCALE_LOG2   = 0,
    parameter int unsigned X0           = 260,
    parameter int unsigned Y0           = 277,
    parameter logic [11:0] KEY          = 12'hFFF,
    parameter int unsigned ROM_LAT      = 1,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter int unsigned REVEAL_STEP  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             bright,
    input  logic [9:0]       hCount,
    input  logic [9:0]       vCount,
    input  logic [11:0]      background,
    input  logic [9:0]       pos_x,
    input  logic [9:0]       pos_y,
    input  logic             pos_load,
    input  logic [1:0]       mode,
    output logic [ROW_W-1:0] rom_row,
    output logic [COL_W-1:0] rom_col,
    input  logic [11:0]      rom_color,
    output logic [11:0]      rgb,
    output logic             reveal_done
);

    localparam int unsigned CW    = 10;
    localparam int unsigned DW    = 11;
    localparam int unsigned CLR_W = 12;
    localparam int unsigned WIN_W = SPR_W << SCALE_LOG2;
    localparam int unsigned WIN_H = SPR_H << SCALE_LOG2;
    localparam int unsigned RC_W  = $clog2(SPR_W + 1);
    localparam int unsigned BC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic             at_origin, prev_origin, tick;
    logic [CW-1:0]    ax, ay, sx, sy;
    logic             pending;
    logic [DW-1:0]    dx, dy;
    logic             hit, show;

    logic [1:0]       mode_q, mode_n;
    logic [BC_W-1:0]  blink_cnt, blink_n;
    logic             vis, vis_n;
    logic [RC_W-1:0]  reveal_col, rc_n;
    logic [31:0]      rc_sum;

    logic [ROM_LAT-1:0] bright_dl, show_dl;
    logic [CLR_W-1:0]   bg_dl [ROM_LAT];

    // Edge-detected frame tick tolerates pixel-rate clock enables
    assign at_origin = (hCount == '0) && (vCount == '0);
    assign tick      = at_origin && !prev_origin;

    // Shadow/active position: loads take effect only on a frame tick
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_origin <= 1'b0;
            ax          <= CW'(X0);
            ay          <= CW'(Y0);
            sx          <= CW'(X0);
            sy          <= CW'(Y0);
            pending     <= 1'b0;
        end else begin
            prev_origin <= at_origin;
            if (pos_load) begin
                sx <= pos_x;
                sy <= pos_y;
            end
            if (tick) begin
                if (pos_load) begin
                    ax <= pos_x;
                    ay <= pos_y;
                end else if (pending) begin
                    ax <= sx;
                    ay <= sy;
                end
                pending <= 1'b0;
            end else if (pos_load) begin
                pending <= 1'b1;
            end
        end
    end

    // Stage 0: window hit test and ROM address
    assign dx      = DW'(hCount) - DW'(ax);
    assign dy      = DW'(vCount) - DW'(ay);
    assign hit     = en && !dx[DW-1] && !dy[DW-1]
                     && (32'(dx) < WIN_W) && (32'(dy) < WIN_H);
    assign rom_col = COL_W'(dx >> SCALE_LOG2);
    assign rom_row = ROW_W'(dy >> SCALE_LOG2);
    assign show    = hit && ((mode_q != 2'd1) || vis)
                     && ((mode_q != 2'd2) || (32'(rom_col) < 32'(reveal_col)));

    // Mode next-state: advances on frame ticks, cleared whenever en is low
    always_comb begin
        mode_n  = mode_q;
        blink_n = blink_cnt;
        vis_n   = vis;
        rc_n    = reveal_col;
        rc_sum  = 32'(reveal_col) + REVEAL_STEP;
        if (tick) begin
            mode_n = mode;
            if (mode != mode_q) begin
                blink_n = '0;
                vis_n   = 1'b1;
                rc_n    = '0;
            end else if (mode_q == 2'd1) begin
                if (32'(blink_cnt) == BLINK_FRAMES - 1) begin
                    blink_n = '0;
                    vis_n   = !vis;
                end else begin
                    blink_n = blink_cnt + BC_W'(1);
                end
            end else if (mode_q == 2'd2) begin
                rc_n = (rc_sum >= SPR_W) ? RC_W'(SPR_W) : RC_W'(rc_sum);
            end
        end
        if (!en) begin
            blink_n = '0;
            vis_n   = 1'b1;
            rc_n    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= 2'd0;
            blink_cnt   <= '0;
            vis         <= 1'b1;
            reveal_col  <= '0;
            reveal_done <= 1'b0;
        end else begin
            mode_q      <= mode_n;
            blink_cnt   <= blink_n;
            vis         <= vis_n;
            reveal_col  <= rc_n;
            reveal_done <= (mode_n == 2'd2) && (rc_n == RC_W'(SPR_W));
        end
    end

    // Delay line aligning pixel controls with ROM data
    always_ff @(posedge clk) begin
        if (rst) begin
            bright_dl <= '0;
            show_dl   <= '0;
            for (int i = 0; i < ROM_LAT; i++) bg_dl[i] <= '0;
        end else begin
            bright_dl[0] <= bright;
            show_dl[0]   <= show;
            bg_dl[0]     <= background;
            for (int i = 1; i < ROM_LAT; i++) begin
                bright_dl[i] <= bright_dl[i-1];
                show_dl[i]   <= show_dl[i-1];
                bg_dl[i]     <= bg_dl[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb <= '0;
        end else if (!bright_dl[ROM_LAT-1]) begin
            rgb <= '0;
        end else if (show_dl[ROM_LAT-1] && (rom_color != KEY)) begin
            rgb <= rom_color;
        end else begin
            rgb <= bg_dl[ROM_LAT-1];
        end
    end

endmodule

// File: tb/tb_sprite_overlay_controller.sv
// Directed bench for sprite_overlay_controller: static table, scaling, move,
// blink, reveal, blanking and mid-line reset.
module tb_sprite_overlay_controller;

    localparam logic [11:0] BG = 12'h123;

    logic        clk = 1'b0;
    logic        rst, en, bright, pos_load;
    logic [9:0]  hCount, vCount, pos_x, pos_y;
    logic [11:0] background;
    logic [1:0]  mode;
    logic [3:0]  rom_row, rom_row_s;
    logic [6:0]  rom_col, rom_col_s;
    logic [11:0] rom_color, rom_color_s, rgb, rgb_s;
    logic        reveal_done, reveal_done_s;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sprite_overlay_controller #(.BLINK_FRAMES(2), .REVEAL_STEP(30)) dut (
        .clk(clk), .rst(rst), .en(en), .bright(bright),
        .hCount(hCount), .vCount(vCount), .background(background),
        .pos_x(pos_x), .pos_y(pos_y), .pos_load(pos_load), .mode(mode),
        .rom_row(rom_row), .rom_col(rom_col), .rom_color(rom_color),
        .rgb(rgb), .reveal_done(reveal_done)
    );

    sprite_overlay_controller #(.SCALE_LOG2(1), .BLINK_FRAMES(2), .REVEAL_STEP(30)) dut_s (
        .clk(clk), .rst(rst), .en(en), .bright(bright),
        .hCount(hCount), .vCount(vCount), .background(background),
        .pos_x(pos_x), .pos_y(pos_y), .pos_load(pos_load), .mode(mode),
        .rom_row(rom_row_s), .rom_col(rom_col_s), .rom_color(rom_color_s),
        .rgb(rgb_s), .reveal_done(reveal_done_s)
    );

    function automatic logic [11:0] rom_fn(input logic [3:0] r, input logic [6:0] c);
        if (r == 4'd0 && c == 7'd0) return 12'h0F0;
        if (c == 7'd5) return 12'hFFF;
        return {r ^ 4'h8, 1'b0, c};
    endfunction

    // One-cycle ROM models
    always @(posedge clk) begin
        rom_color   <= rom_fn(rom_row, rom_col);
        rom_color_s <= rom_fn(rom_row_s, rom_col_s);
    end

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Hold a pixel long enough for its colour to reach rgb
    task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic br);
        @(posedge clk) #1;
        hCount = h; vCount = v; bright = br; background = BG;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic ld, input logic [9:0] x, input logic [9:0] y);
        @(posedge clk) #1;
        hCount = 10'd0; vCount = 10'd0; pos_load = ld; pos_x = x; pos_y = y;
        @(posedge clk) #1;
        pos_load = 1'b0; hCount = 10'd5; vCount = 10'd5;
    endtask

    task automatic load(input logic [9:0] x, input logic [9:0] y);
        @(posedge clk) #1;
        pos_x = x; pos_y = y; pos_load = 1'b1;
        @(posedge clk) #1;
        pos_load = 1'b0;
    endtask

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        br;
        logic [11:0] exp;
    } vec_t;

    vec_t vt [10];
    logic blink_exp [7];

    initial begin
        vt[0] = '{10'd260, 10'd277, 1'b1, 12'h0F0};
        vt[1] = '{10'd261, 10'd277, 1'b1, 12'h801};
        vt[2] = '{10'd349, 10'd278, 1'b1, 12'h959};
        vt[3] = '{10'd350, 10'd277, 1'b1, BG};
        vt[4] = '{10'd265, 10'd277, 1'b1, BG};
        vt[5] = '{10'd259, 10'd277, 1'b1, BG};
        vt[6] = '{10'd260, 10'd287, 1'b1, 12'h200};
        vt[7] = '{10'd260, 10'd288, 1'b1, BG};
        vt[8] = '{10'd300, 10'd276, 1'b1, BG};
        vt[9] = '{10'd260, 10'd277, 1'b0, 12'h000};
        blink_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; en = 1'b1; bright = 1'b0; pos_load = 1'b0; mode = 2'd0;
        hCount = 10'd5; vCount = 10'd5; pos_x = '0; pos_y = '0; background = BG;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rgb", rgb, 12'h000);
        chk("reset_done", 12'(reveal_done), 12'h000);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            pix(vt[i].h, vt[i].v, vt[i].br);
            chk($sformatf("vec%0d", i), rgb, vt[i].exp);
        end

        // Scaled instance
        @(posedge clk) #1; hCount = 10'd262; vCount = 10'd279; #1;
        chk("scale_row_a", 12'(rom_row_s), 12'd1);
        chk("scale_col_a", 12'(rom_col_s), 12'd1);
        @(posedge clk) #1; hCount = 10'd263; vCount = 10'd280; #1;
        chk("scale_row_b", 12'(rom_row_s), 12'd1);
        chk("scale_col_b", 12'(rom_col_s), 12'd1);
        pix(10'd439, 10'd277, 1'b1); chk("scale_edge_in", rgb_s, 12'h859);
        pix(10'd440, 10'd277, 1'b1); chk("scale_edge_out", rgb_s, BG);

        // Move: deferred until tick, and applied on a coincident load
        load(10'd100, 10'd50);
        pix(10'd260, 10'd277, 1'b1); chk("move_old_kept", rgb, 12'h0F0);
        pix(10'd100, 10'd50, 1'b1);  chk("move_new_wait", rgb, BG);
        frame(1'b0, 10'd0, 10'd0);
        pix(10'd100, 10'd50, 1'b1);  chk("move_new_on", rgb, 12'h0F0);
        pix(10'd260, 10'd277, 1'b1); chk("move_old_off", rgb, BG);
        frame(1'b1, 10'd200, 10'd100);
        pix(10'd200, 10'd100, 1'b1); chk("move_tick_on", rgb, 12'h0F0);
        pix(10'd100, 10'd50, 1'b1);  chk("move_tick_old", rgb, BG);
        load(10'd260, 10'd277);
        frame(1'b0, 10'd0, 10'd0);

        // Blink
        mode = 2'd1;
        for (int f = 0; f < 7; f++) begin
            frame(1'b0, 10'd0, 10'd0);
            pix(10'd260, 10'd277, 1'b1);
            chk($sformatf("blink_f%0d", f), rgb, blink_exp[f] ? 12'h0F0 : BG);
        end
        @(posedge clk) #1; en = 1'b0;
        @(posedge clk) #1; en = 1'b1;
        pix(10'd260, 10'd277, 1'b1); chk("blink_restart", rgb, 12'h0F0);
        frame(1'b0, 10'd0, 10'd0);
        pix(10'd260, 10'd277, 1'b1); chk("blink_r1", rgb, 12'h0F0);
        frame(1'b0, 10'd0, 10'd0);
        pix(10'd260, 10'd277, 1'b1); chk("blink_r2", rgb, BG);

        // Reveal
        mode = 2'd2;
        frame(1'b0, 10'd0, 10'd0);
        pix(10'd260, 10'd277, 1'b1); chk("reveal_f0", rgb, BG);
        chk("reveal_done_f0", 12'(reveal_done), 12'd0);
        frame(1'b0, 10'd0, 10'd0);
        pix(10'd260, 10'd277, 1'b1); chk("reveal_f1_c0", rgb, 12'h0F0);
        pix(10'd289, 10'd277, 1'b1); chk("reveal_f1_c29", rgb, 12'h81D);
        pix(10'd290, 10'd277, 1'b1); chk("reveal_f1_c30", rgb, BG);
        frame(1'b0, 10'd0, 10'd0);
        pix(10'd319, 10'd277, 1'b1); chk("reveal_f2_c59", rgb, 12'h83B);
        pix(10'd320, 10'd277, 1'b1); chk("reveal_f2_c60", rgb, BG);
        chk("reveal_done_f2", 12'(reveal_done), 12'd0);
        frame(1'b0, 10'd0, 10'd0);
        chk("reveal_done_f3", 12'(reveal_done), 12'd1);
        pix(10'd349, 10'd277, 1'b1); chk("reveal_f3_c89", rgb, 12'h859);
        mode = 2'd0;
        frame(1'b0, 10'd0, 10'd0);
        chk("reveal_done_clr", 12'(reveal_done), 12'd0);
        pix(10'd349, 10'd277, 1'b1); chk("static_c89", rgb, 12'h859);

        // Mid-line reset reverts position and blanks output
        load(10'd100, 10'd50);
        frame(1'b0, 10'd0, 10'd0);
        pix(10'd100, 10'd50, 1'b1);  chk("pre_rst_pos", rgb, 12'h0F0);
        @(posedge clk) #1; rst = 1'b1;
        @(posedge clk) #1; chk("rst_rgb", rgb, 12'h000);
        rst = 1'b0;
        pix(10'd260, 10'd277, 1'b1); chk("rst_pos_home", rgb, 12'h0F0);
        pix(10'd100, 10'd50, 1'b1);  chk("rst_pos_old", rgb, BG);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
